// File: rtl/dp_ram_cdc_pkg.sv
// rtl/dp_ram_cdc_pkg.sv - shared defaults and word type for the dual-port RAM
package dp_ram_cdc_pkg;

   localparam int DP_DATA_WIDTH = 8;
   localparam int DP_ADDR_WIDTH = 4;

   typedef logic [DP_DATA_WIDTH-1:0] word_t;

endpackage : dp_ram_cdc_pkg

// File: rtl/dp_ram_cdc.sv
// rtl/dp_ram_cdc.sv - single-clock true dual-port RAM, read-first, port A wins write collisions
module dp_ram_cdc
   import dp_ram_cdc_pkg::*;
#(
   parameter int DATA_WIDTH = DP_DATA_WIDTH,
   parameter int ADDR_WIDTH = DP_ADDR_WIDTH,
   localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
   logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
   logic                  collision;
   logic                  wr_b_en;

   always_comb begin
      mem_d     = mem_q;
      // Reads sample the array before this edge's writes land.
      dout_a_d  = mem_q[addr_a];
      dout_b_d  = mem_q[addr_b];
      collision = we_a & we_b & (addr_a == addr_b);
      wr_b_en   = we_b & ~collision;
      if (wr_b_en) mem_d[addr_b] = din_b;
      if (we_a)    mem_d[addr_a] = din_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         dout_a_q <= '0;
         dout_b_q <= '0;
      end else begin
         mem_q    <= mem_d;
         dout_a_q <= dout_a_d;
         dout_b_q <= dout_b_d;
      end
   end

   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;

endmodule : dp_ram_cdc

// File: tb/tb_dp_ram_cdc.sv
// tb/tb_dp_ram_cdc.sv - directed self-checking bench for dp_ram_cdc
module tb_dp_ram_cdc;
   import dp_ram_cdc_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  we_a, we_b;
   logic  [DP_ADDR_WIDTH-1:0] addr_a, addr_b;
   word_t din_a, din_b, dout_a, dout_b;

   int vectors = 0;
   int miscompares = 0;

   dp_ram_cdc dut (
      .clk    (clk),
      .rst    (rst),
      .we_a   (we_a),
      .addr_a (addr_a),
      .din_a  (din_a),
      .dout_a (dout_a),
      .we_b   (we_b),
      .addr_b (addr_b),
      .din_b  (din_b),
      .dout_b (dout_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input word_t observed, input word_t expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; we_a = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_dout_a", dout_a, 8'h00);
      check("reset_dout_b", dout_b, 8'h00);

      for (int i = 0; i < 16; i++) begin
         addr_a = 4'(i);
         addr_b = 4'(15 - i);
         tick();
         check("reset_clear_a", dout_a, 8'h00);
         check("reset_clear_b", dout_b, 8'h00);
      end

      we_a = 1'b1; addr_a = 4'h1; din_a = 8'hAA; tick();
      addr_a = 4'h2; din_a = 8'hBB; tick();
      we_a = 1'b0; addr_a = 4'h1; addr_b = 4'h1; tick();
      check("a_read_1", dout_a, 8'hAA);
      check("b_read_1", dout_b, 8'hAA);
      addr_a = 4'h2; tick();
      check("a_read_2", dout_a, 8'hBB);

      we_b = 1'b1; addr_b = 4'h3; din_b = 8'hCC; tick();
      we_b = 1'b0; addr_a = 4'h3; addr_b = 4'h3; tick();
      check("a_read_3", dout_a, 8'hCC);
      check("b_read_3", dout_b, 8'hCC);

      we_a = 1'b1; we_b = 1'b1; addr_a = 4'h1; addr_b = 4'h1;
      din_a = 8'hAA; din_b = 8'hDD; tick();
      we_a = 1'b0; we_b = 1'b0; tick();
      check("collision_a", dout_a, 8'hAA);
      check("collision_b", dout_b, 8'hAA);

      we_b = 1'b1; din_b = 8'hDD; tick();
      we_b = 1'b0; tick();
      check("b_only_a", dout_a, 8'hDD);
      check("b_only_b", dout_b, 8'hDD);

      we_a = 1'b1; addr_a = 4'h5; din_a = 8'h11; tick();
      din_a = 8'h22; addr_b = 4'h5; tick();
      check("rdfirst_b_old", dout_b, 8'h11);
      check("rdfirst_a_old", dout_a, 8'h11);
      we_a = 1'b0; tick();
      check("rdfirst_b_new", dout_b, 8'h22);
      check("rdfirst_a_new", dout_a, 8'h22);

      rst = 1'b1; we_a = 1'b1; addr_a = 4'h4; din_a = 8'h77; tick();
      rst = 1'b0; we_a = 1'b0;
      check("midrst_dout_a", dout_a, 8'h00);
      check("midrst_dout_b", dout_b, 8'h00);
      for (int i = 0; i < 16; i++) begin
         addr_a = 4'(i);
         addr_b = 4'(i);
         tick();
         check("midrst_clear_a", dout_a, 8'h00);
         check("midrst_clear_b", dout_b, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_dp_ram_cdc

// File: doc/dp_ram_cdc.md
Name: dp_ram_cdc

Overview:
- True dual-port RAM with two independent read/write ports, A and B, both synchronous to one shared clock.
- It sits at the boundary between two request streams that have already been retimed into a common clock domain upstream.
- It provides deterministic arbitration when both ports write the same word in the same cycle.
- Reads are registered.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of the din/dout buses.
- ADDR_WIDTH, 4, width of the address buses.
- DEPTH, 2**ADDR_WIDTH (16), number of words. Derived from ADDR_WIDTH; not overridden independently.

Ports:
- clk  input  1  single clock for both ports; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- we_a  input  1  port A write enable.
- addr_a  input  ADDR_WIDTH  port A address.
- din_a  input  DATA_WIDTH  port A write data.
- dout_a  output  DATA_WIDTH  port A registered read data.
- we_b  input  1  port B write enable.
- addr_b  input  ADDR_WIDTH  port B address.
- din_b  input  DATA_WIDTH  port B write data.
- dout_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst). Both ports are synchronous to clk.
- Reset: while rst=1 at a rising edge:
  - dout_a and dout_b are set to 0.
  - All DEPTH memory words are cleared to 0.
  - Writes are ignored.
- Write: we_x=1 at a rising edge writes din_x to mem[addr_x]. The new value is visible to reads on the next edge.
- Read: every cycle (we_x=0 or 1), dout_x registers mem[addr_x] as it stood before this edge's writes (read-first). Latency is 1 clock from address to dout.
- Same-port read-during-write: dout_x returns the old contents. The new data appears on a read one cycle later.
- Cross-port read-during-write (port X reads the address port Y writes in the same cycle): dout_x returns the old contents.
- Write collision (we_a=1, we_b=1, addr_a==addr_b, same edge):
  - Port A wins; din_a is stored.
  - Port B's write is dropped silently, with no retry and no flag.
- Writes from both ports to different addresses in the same cycle both take effect.
- Addresses cover the full range 0..DEPTH-1; no out-of-range case exists.
- dout_x holds its last value only until the next edge; it updates on every non-reset edge.
- Reset asserted mid-sequence: takes effect on that edge and overrides any simultaneous write.

Decomposition:
- Shared package: default DATA_WIDTH/ADDR_WIDTH constants and a word typedef (logic [DATA_WIDTH-1:0]).
- No sub-module is required. Memory array, collision compare (we_a & we_b & addr_a==addr_b) and the two output registers live in one module.
- The collision-resolve logic may optionally be factored into dp_ram_wr_arb.

Test Plan:
- Reset: hold rst=1 for 2 cycles, release → dout_a=dout_b=0x00; reads of addresses 0x0..0xF return 0x00.
- Port A writes: A writes 0x1=0xAA, then 0x2=0xBB; A reads 0x1, then 0x2 → dout_a=0xAA, 0xBB, each 1 cycle after the address is applied. B reads 0x1 → dout_b=0xAA.
- Port B write, no conflict: B writes 0x3=0xCC; later A reads 0x3 → 0xCC and B reads 0x3 → 0xCC.
- Collision: same edge, A writes 0x1=0xAA and B writes 0x1=0xDD → both ports then read 0x1=0xAA. Separately, B alone writes 0x1=0xDD in a later cycle → reads return 0xDD.
- Read-first: mem[0x5]=0x11; A writes 0x5=0x22 while B reads 0x5 in the same cycle → dout_b=0x11 next cycle, 0x22 the cycle after.
- Reset mid-operation: after the writes above, assert rst for one edge with we_a=1, addr_a=0x4, din_a=0x77 → outputs 0; all words, including 0x4, read 0x00 afterwards.
